// File: rtl/hazard_scoreboard_id_if.sv
// hazard_scoreboard_id_if: ID-stage issue request and interlock/bypass response bundle
interface hazard_scoreboard_id_if #(
    parameter int REG_SIZE = 5,
    parameter int LAT_W    = 2
);
    logic                id_valid_i;
    logic [REG_SIZE-1:0] src_a_id_i;
    logic [REG_SIZE-1:0] src_b_id_i;
    logic                rd_src_a_id_i;
    logic                rd_src_b_id_i;
    logic [REG_SIZE-1:0] dst_id_i;
    logic                wr_dst_id_i;
    logic [LAT_W-1:0]    lat_id_i;
    logic                flush_i;
    logic                id_ready_o;
    logic                stall_o;
    logic [1:0]          mux_sel_a_id_o;
    logic [1:0]          mux_sel_b_id_o;

    modport master (
        output id_valid_i, src_a_id_i, src_b_id_i, rd_src_a_id_i, rd_src_b_id_i,
        output dst_id_i, wr_dst_id_i, lat_id_i, flush_i,
        input  id_ready_o, stall_o, mux_sel_a_id_o, mux_sel_b_id_o
    );

    modport slave (
        input  id_valid_i, src_a_id_i, src_b_id_i, rd_src_a_id_i, rd_src_b_id_i,
        input  dst_id_i, wr_dst_id_i, lat_id_i, flush_i,
        output id_ready_o, stall_o, mux_sel_a_id_o, mux_sel_b_id_o
    );
endinterface

// File: rtl/hazard_scoreboard_id.sv
// hazard_scoreboard_id: decode-stage RAW interlock and bypass-select scoreboard; HAZARD_SCOREBOARD_STATS_EN adds a stall counter
module hazard_scoreboard_id #(
    parameter int REG_SIZE = 5,
    parameter int NUM_REGS = 32,
    parameter int LAT_W    = 2
) (
    input  logic                  clk_i,
    input  logic                  rsn_i,
    hazard_scoreboard_id_if.slave bus
`ifdef HAZARD_SCOREBOARD_STATS_EN
    ,
    input  logic                  stat_clr_i,
    output logic [31:0]           stall_cnt_o
`endif
);
    localparam logic [1:0]       ST_EX   = 2'd1;
    localparam logic [1:0]       ST_WB   = 2'd3;
    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(2);

    logic             r_pend  [NUM_REGS];
    logic [1:0]       r_stage [NUM_REGS];
    logic [LAT_W-1:0] r_rem   [NUM_REGS];

    logic             w_use_a;
    logic             w_use_b;
    logic             w_haz_a;
    logic             w_haz_b;
    logic             w_ready;
    logic             w_stall;
    logic             w_alloc;
    logic [LAT_W-1:0] w_lat;

    // An operand is bypassed from its producer only when it is really read from a non-zero register in flight
    assign w_use_a = bus.rd_src_a_id_i && (bus.src_a_id_i != '0) && r_pend[bus.src_a_id_i];
    assign w_use_b = bus.rd_src_b_id_i && (bus.src_b_id_i != '0) && r_pend[bus.src_b_id_i];
    assign w_haz_a = w_use_a && (r_rem[bus.src_a_id_i] != '0);
    assign w_haz_b = w_use_b && (r_rem[bus.src_b_id_i] != '0);
    assign w_ready = ~(w_haz_a | w_haz_b);
    assign w_stall = bus.id_valid_i & ~w_ready;
    assign w_alloc = bus.id_valid_i && w_ready && !bus.flush_i && bus.wr_dst_id_i && (bus.dst_id_i != '0);
    assign w_lat   = (bus.lat_id_i > LAT_MAX) ? LAT_MAX : bus.lat_id_i;

    assign bus.id_ready_o     = w_ready;
    assign bus.stall_o        = w_stall;
    assign bus.mux_sel_a_id_o = w_use_a ? r_stage[bus.src_a_id_i] : 2'b00;
    assign bus.mux_sel_b_id_o = w_use_b ? r_stage[bus.src_b_id_i] : 2'b00;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
        // Issuing writer claims the entry (newest wins); otherwise an in-flight entry ages one stage per clock
        always_ff @(posedge clk_i or negedge rsn_i) begin
            if (!rsn_i) begin
                r_pend[g]  <= 1'b0;
                r_stage[g] <= 2'b00;
                r_rem[g]   <= '0;
            end else if (w_alloc && (bus.dst_id_i == REG_SIZE'(g))) begin
                r_pend[g]  <= 1'b1;
                r_stage[g] <= ST_EX;
                r_rem[g]   <= w_lat;
            end else if (r_pend[g]) begin
                if (r_stage[g] == ST_WB) begin
                    r_pend[g]  <= 1'b0;
                    r_stage[g] <= 2'b00;
                    r_rem[g]   <= '0;
                end else begin
                    r_stage[g] <= r_stage[g] + 2'd1;
                    r_rem[g]   <= (r_rem[g] == '0) ? '0 : r_rem[g] - LAT_W'(1);
                end
            end
        end
    end

`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [31:0] r_stall_cnt;

    // Free-running stall cycle counter; clear wins over increment
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i)
            r_stall_cnt <= '0;
        else if (stat_clr_i)
            r_stall_cnt <= '0;
        else if (w_stall)
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt_o = r_stall_cnt;
`endif
endmodule

// File: tb/tb_hazard_scoreboard_id.sv
// tb_hazard_scoreboard_id: directed vector table, reset corner cases and random traffic against an age-based model
module tb_hazard_scoreboard_id;
    localparam int RS = 5;
    localparam int NR = 32;
    localparam int LW = 2;

    logic clk = 1'b0;
    logic rsn = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard_id_if #(.REG_SIZE(RS), .LAT_W(LW)) bus ();

`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic        stat_clr = 1'b0;
    logic [31:0] stall_cnt;
`endif

    hazard_scoreboard_id #(.REG_SIZE(RS), .NUM_REGS(NR), .LAT_W(LW)) dut (
        .clk_i(clk),
        .rsn_i(rsn),
        .bus(bus)
`ifdef HAZARD_SCOREBOARD_STATS_EN
        ,
        .stat_clr_i(stat_clr),
        .stall_cnt_o(stall_cnt)
`endif
    );

    typedef struct {
        logic        v;
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic        ra;
        logic        rb;
        logic [4:0]  dst;
        logic        wr;
        logic [1:0]  lat;
        logic        fl;
        logic        rdy;
        logic [1:0]  xa;
        logic [1:0]  xb;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: remember the latest issued writer of each register and its issue cycle.
    // Age 1/2/3 after issue means EX/MEM/WB; the value is bypassable once age exceeds the clamped latency.
    bit          has [NR];
    int          lc  [NR];
    int          ll  [NR];
    int          cyc = 0;
    logic [31:0] m_stalls = 0;

    function automatic vec_t mk(logic v, logic [4:0] sa, logic [4:0] sb, logic ra, logic rb,
                                logic [4:0] dst, logic wr, logic [1:0] lat, logic fl,
                                logic rdy, logic [1:0] xa, logic [1:0] xb);
        vec_t t;
        t.v = v; t.sa = sa; t.sb = sb; t.ra = ra; t.rb = rb; t.dst = dst; t.wr = wr;
        t.lat = lat; t.fl = fl; t.rdy = rdy; t.xa = xa; t.xb = xb;
        return t;
    endfunction

    function automatic void m_op(input logic [4:0] idx, input logic rd, output logic haz, output logic [1:0] sel);
        int  age;
        bit  p;
        age = cyc - lc[idx];
        p   = rd && (idx != 0) && has[idx] && (age >= 1) && (age <= 3);
        haz = p && (age <= ll[idx]);
        sel = p ? 2'(age) : 2'b00;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < NR; i++) has[i] = 0;
        m_stalls = 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.id_valid_i    = v.v;
        bus.src_a_id_i    = v.sa;
        bus.src_b_id_i    = v.sb;
        bus.rd_src_a_id_i = v.ra;
        bus.rd_src_b_id_i = v.rb;
        bus.dst_id_i      = v.dst;
        bus.wr_dst_id_i   = v.wr;
        bus.lat_id_i      = v.lat;
        bus.flush_i       = v.fl;
    endtask

    // Called at a negedge: apply inputs, compare mid-cycle, then advance the model across the posedge
    task automatic run_cycle(input vec_t v, input bit tbl);
        logic       ha, hb, mr, er;
        logic [1:0] ma, mb, ea, eb;
        drive(v);
        #1;
        m_op(v.sa, v.ra, ha, ma);
        m_op(v.sb, v.rb, hb, mb);
        mr = ~(ha | hb);
        er = tbl ? v.rdy : mr;
        ea = tbl ? v.xa : ma;
        eb = tbl ? v.xb : mb;
        chk("id_ready", 32'(bus.id_ready_o), 32'(er));
        chk("stall", 32'(bus.stall_o), 32'(v.v & ~er));
        chk("sel_a", 32'(bus.mux_sel_a_id_o), 32'(ea));
        chk("sel_b", 32'(bus.mux_sel_b_id_o), 32'(eb));
`ifdef HAZARD_SCOREBOARD_STATS_EN
        chk("stall_cnt", stall_cnt, m_stalls);
`endif
        @(posedge clk);
        if (v.v && mr && !v.fl && v.wr && v.dst != 0) begin
            has[v.dst] = 1;
            lc[v.dst]  = cyc;
            ll[v.dst]  = (v.lat > 2) ? 2 : int'(v.lat);
        end
`ifdef HAZARD_SCOREBOARD_STATS_EN
        if (stat_clr) m_stalls = 0;
        else if (v.v && !mr) m_stalls = m_stalls + 1;
`endif
        cyc++;
        @(negedge clk);
    endtask

    // Hold reset across one rising edge while ID shows a read of x5; outputs must already be idle
    task automatic pulse_reset();
        drive(mk(1, 5, 5, 1, 1, 0, 0, 0, 0, 1, 0, 0));
        rsn = 1'b0;
        #1;
        chk("rst_ready", 32'(bus.id_ready_o), 32'd1);
        chk("rst_stall", 32'(bus.stall_o), 32'd0);
        chk("rst_sel_a", 32'(bus.mux_sel_a_id_o), 32'd0);
        chk("rst_sel_b", 32'(bus.mux_sel_b_id_o), 32'd0);
`ifdef HAZARD_SCOREBOARD_STATS_EN
        chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        rsn = 1'b1;
        m_clear();
        cyc++;
    endtask

    vec_t tbl[$];
    vec_t r;

    initial begin
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        m_clear();
        @(negedge clk);
        pulse_reset();

        //            v sa  sb ra rb dst wr lat fl  rdy xa xb
        tbl.push_back(mk(1, 0, 0, 0, 0, 5, 1, 1, 0,  1, 0, 0)); // load x5
        tbl.push_back(mk(1, 5, 0, 1, 0, 0, 0, 0, 0,  0, 1, 0)); // load-use stall
        tbl.push_back(mk(1, 5, 0, 1, 0, 0, 0, 0, 0,  1, 2, 0)); // resolved from MEM
        tbl.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0, 0,  1, 0, 0)); // add x3
        tbl.push_back(mk(1, 0, 3, 0, 1, 0, 0, 0, 0,  1, 0, 1)); // rs2 x3 from EX
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0,  1, 0, 0)); // add x7
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0)); // bubble
        tbl.push_back(mk(1, 7, 0, 1, 0, 0, 0, 0, 0,  1, 2, 0)); // x7 from MEM
        tbl.push_back(mk(1, 7, 0, 1, 0, 0, 0, 0, 0,  1, 3, 0)); // x7 from WB
        tbl.push_back(mk(1, 7, 0, 1, 0, 0, 0, 0, 0,  1, 0, 0)); // x7 retired
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 2, 0,  1, 0, 0)); // write x0
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0,  1, 0, 0)); // read x0 both
        tbl.push_back(mk(1, 0, 0, 0, 0, 9, 1, 2, 0,  1, 0, 0)); // x9 long
        tbl.push_back(mk(1, 0, 0, 0, 0, 9, 1, 0, 0,  1, 0, 0)); // x9 alu, WAW
        tbl.push_back(mk(1, 9, 0, 1, 0, 0, 0, 0, 0,  1, 1, 0)); // newest x9 wins
        tbl.push_back(mk(1, 0, 0, 0, 0, 4, 1, 0, 1,  1, 0, 0)); // flushed write x4
        tbl.push_back(mk(1, 4, 0, 1, 0, 0, 0, 0, 0,  1, 0, 0)); // x4 not pending
        tbl.push_back(mk(1, 0, 0, 0, 0, 8, 1, 1, 0,  1, 0, 0)); // load x8
        tbl.push_back(mk(1, 8, 0, 1, 0, 6, 1, 0, 0,  0, 1, 0)); // stalled writer of x6
        tbl.push_back(mk(1, 8, 0, 1, 0, 6, 1, 0, 1,  1, 2, 0)); // now flushed
        tbl.push_back(mk(1, 6, 0, 1, 0, 0, 0, 0, 0,  1, 0, 0)); // no x6 entry
        tbl.push_back(mk(1, 0, 0, 0, 0, 6, 1, 0, 0,  1, 0, 0)); // x6 issues
        tbl.push_back(mk(1, 6, 0, 1, 0, 0, 0, 0, 0,  1, 1, 0)); // x6 from EX
        tbl.push_back(mk(1, 0, 0, 0, 0, 11, 1, 3, 0, 1, 0, 0)); // lat 3 clamps to 2
        tbl.push_back(mk(1, 0, 11, 0, 1, 0, 0, 0, 0, 0, 0, 1)); // stall 1
        tbl.push_back(mk(1, 0, 11, 0, 1, 0, 0, 0, 0, 0, 0, 2)); // stall 2
        tbl.push_back(mk(1, 0, 11, 0, 1, 0, 0, 0, 0, 1, 0, 3)); // ready at WB
        foreach (tbl[i]) run_cycle(tbl[i], 1'b1);

        // Reset in flight: load x5 then reset; x5 must be clean afterwards
        run_cycle(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 1, 0, 0), 1'b1);
        pulse_reset();
        run_cycle(mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0), 1'b1);

`ifdef HAZARD_SCOREBOARD_STATS_EN
        // Clear must win over a simultaneous stall
        run_cycle(mk(1, 0, 0, 0, 0, 12, 1, 2, 0, 1, 0, 0), 1'b1);
        run_cycle(mk(1, 12, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0), 1'b1);
        stat_clr = 1'b1;
        run_cycle(mk(1, 12, 0, 1, 0, 0, 0, 0, 0, 0, 2, 0), 1'b1);
        stat_clr = 1'b0;
        run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1'b1);
`endif

        for (int k = 0; k < 400; k++) begin
            r.v   = 1'($urandom_range(0, 3) != 0);
            r.sa  = 5'($urandom_range(0, 7));
            r.sb  = 5'($urandom_range(0, 7));
            r.ra  = 1'($urandom_range(0, 1));
            r.rb  = 1'($urandom_range(0, 1));
            r.dst = 5'($urandom_range(0, 7));
            r.wr  = 1'($urandom_range(0, 3) != 0);
            r.lat = 2'($urandom_range(0, 3));
            r.fl  = 1'($urandom_range(0, 7) == 0);
            r.rdy = 1'b0;
            r.xa  = 2'b00;
            r.xb  = 2'b00;
`ifdef HAZARD_SCOREBOARD_STATS_EN
            stat_clr = 1'($urandom_range(0, 15) == 0);
`endif
            if (k == 200) pulse_reset();
            run_cycle(r, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
